// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the program loader.
package prog_loader_pkg;

    localparam int CSUM_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } loader_state_t;

    function automatic int bytes_per_instr(input int i_size);
        return (i_size + 7) / 8;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream input and program memory write port of the loader.
interface prog_loader_if #(
    parameter int p_size = 6,
    parameter int i_size = 24
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [p_size-1:0] wr_addr;
    logic [i_size-1:0] wr_data;

    // Stream source / memory side
    modport master (
        output in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    // Loader side
    modport slave (
        input  in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/prog_loader_instr_packer.sv
// Packs BPI bytes, MSB first, into one instruction word. The word output and
// the completion pulse are combinational on the byte that finishes the word,
// so the parent can register them in the same cycle.
module instr_packer
    import prog_loader_pkg::*;
#(
    parameter int i_size = 24
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic [i_size-1:0] word_o,
    output logic              word_complete_o
);
    localparam int BPI   = bytes_per_instr(i_size);
    localparam int IDX_W = (BPI > 1) ? $clog2(BPI) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPI - 1);

    logic [IDX_W-1:0] idx_q;

    // Byte index within the current word; wraps after the last byte.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clear_i) begin
            idx_q <= '0;
        end else if (byte_valid_i) begin
            idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    assign word_complete_o = byte_valid_i && (idx_q == IDX_LAST);

    // Only the earlier BPI-1 bytes need storing; the final byte is taken
    // straight from the input. Excess high bits of the first byte fall off
    // in the truncating cast.
    if (BPI > 1) begin : g_hist
        localparam int HIST_W = (BPI - 1) * 8;
        logic [HIST_W-1:0] hist_q;

        // Shift history left one byte per accepted byte.
        always_ff @(posedge clk_i) begin
            if (!rst_n_i || clear_i) begin
                hist_q <= '0;
            end else if (byte_valid_i) begin
                hist_q <= (hist_q << 8) | HIST_W'(byte_i);
            end
        end

        assign word_o = i_size'({hist_q, byte_i});
    end else begin : g_single
        assign word_o = i_size'(byte_i);
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: count byte, N packed instructions,
// checksum byte. Writes each word to program memory and holds the CPU
// until the load finishes.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | out of reset, waiting for start
// S_COUNT | expecting the instruction count byte
// S_DATA  | receiving instruction bytes, writing completed words
// S_CHECK | expecting the checksum byte
// S_DONE  | load good, CPU released
// S_ERR   | framing or checksum failure, CPU still held
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int p_size = 6,
    parameter int i_size = 24
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic         start,
    prog_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);
    // Largest legal count; 9 bits so p_size = 8 (256) is representable.
    localparam logic [8:0] MAX_N = 9'(1 << p_size);

    loader_state_t     state_q;
    logic [p_size-1:0] addr_q;
    logic [7:0]        remain_q;
    logic [CSUM_W-1:0] acc_q;
    logic              in_ready_q;
    logic              wr_en_q;
    logic [p_size-1:0] wr_addr_q;
    logic [i_size-1:0] wr_data_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              error_q;

    logic              accept;
    logic              start_ok;
    logic              count_bad;
    logic [CSUM_W-1:0] acc_d;
    logic              pk_valid;
    logic [i_size-1:0] pk_word;
    logic              pk_complete;

    assign accept    = bus.in_valid && in_ready_q;
    assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                 (state_q == S_ERR));
    assign count_bad = (bus.in_data == 8'd0) || ({1'b0, bus.in_data} > MAX_N);
    assign acc_d     = acc_q + bus.in_data;
    assign pk_valid  = accept && (state_q == S_DATA);

    instr_packer #(.i_size(i_size)) u_packer (
        .clk_i           (Clock),
        .rst_n_i         (nReset),
        .clear_i         (start_ok),
        .byte_valid_i    (pk_valid),
        .byte_i          (bus.in_data),
        .word_o          (pk_word),
        .word_complete_o (pk_complete)
    );

    // Load sequencing FSM with all outputs registered.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            acc_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state_q    <= S_COUNT;
                        addr_q     <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (accept) begin
                        acc_q <= acc_d;
                        if (count_bad) begin
                            state_q    <= S_ERR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q  <= S_DATA;
                            remain_q <= bus.in_data;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        acc_q <= acc_d;
                    end
                    if (pk_complete) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= addr_q;
                        wr_data_q <= pk_word;
                        addr_q    <= addr_q + 1'b1;
                        remain_q  <= remain_q - 1'b1;
                        if (remain_q == 8'd1) begin
                            state_q <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (accept) begin
                        acc_q      <= acc_d;
                        in_ready_q <= 1'b0;
                        if (acc_d == '0) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule
